// File: rtl/xbar_pkg.sv
// Shared types and helpers for the PSNoC crossbar output ports and their arbiters.
package xbar_pkg;

    localparam int MAX_PORTS = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Keeps only the least-significant set bit; zero in, zero out.
    function automatic logic [MAX_PORTS-1:0] lowest_set_bit(input logic [MAX_PORTS-1:0] vec);
        return vec & (~vec + MAX_PORTS'(1));
    endfunction

endpackage

// File: rtl/onehot_mux.sv
// AND-OR multiplexer from a one-hot select to a {last, data} word; all-zero select gives zero.
module onehot_mux
    import xbar_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic [NUM_INPUTS-1:0]            sel,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data,
    input  logic [NUM_INPUTS-1:0]            last,
    output logic [DATA_WIDTH:0]              out
);

    // NOTE: every always_comb output gets a default before any conditional update, so no latch is inferred.
    always_comb begin
        out = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            out |= {last[i], data[i*DATA_WIDTH +: DATA_WIDTH]} & {(DATA_WIDTH+1){sel[i]}};
        end
    end

endmodule

// File: rtl/xbar_out_port.sv
// Crossbar output port: locks the arbitrated input for a whole packet and registers its flits out.
module xbar_out_port
    import xbar_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]            in_last,
    output logic [NUM_INPUTS-1:0]            in_ready,
    output logic [NUM_INPUTS-1:0]            arb_reqs,
    input  logic [NUM_INPUTS-1:0]            arb_grants,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_last,
    input  logic                             out_ready
);

    state_t                  state;
    logic [NUM_INPUTS-1:0]   owner;
    logic                    rearb;
    logic                    can_load;
    logic [NUM_INPUTS-1:0]   gnt_raw;
    logic [NUM_INPUTS-1:0]   gnt;
    logic [MAX_PORTS-1:0]    gnt_wide;
    logic [NUM_INPUTS-1:0]   sel;
    logic [NUM_INPUTS-1:0]   xfer;
    logic                    xfer_any;
    logic [DATA_WIDTH:0]     mux_out;

    assign can_load = !out_valid || out_ready;
    assign gnt_raw  = arb_grants & in_valid;
    assign gnt_wide = lowest_set_bit(MAX_PORTS'(gnt_raw));
    assign gnt      = gnt_wide[NUM_INPUTS-1:0];

    generate
        if (NUM_INPUTS < MAX_PORTS) begin : g_gnt_hi
            logic unused_gnt_hi;
            assign unused_gnt_hi = |gnt_wide[MAX_PORTS-1:NUM_INPUTS];
        end
    endgenerate

    // The cycle right after a packet ends is spent re-arbitrating, so no flit is taken then.
    always_comb begin
        arb_reqs = in_valid;
        sel      = '0;
        if (state == LOCKED) begin
            arb_reqs = owner;
            sel      = owner;
        end else if (!rearb) begin
            sel = gnt;
        end
        in_ready = (can_load && !rst) ? sel : '0;
    end

    assign xfer     = in_valid & in_ready;
    assign xfer_any = |xfer;

    onehot_mux #(
        .NUM_INPUTS (NUM_INPUTS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mux (
        .sel  (xfer),
        .data (in_data),
        .last (in_last),
        .out  (mux_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            rearb     <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            rearb <= 1'b0;
            if (xfer_any) begin
                out_valid <= 1'b1;
                out_data  <= mux_out[DATA_WIDTH-1:0];
                out_last  <= mux_out[DATA_WIDTH];
                if (state == IDLE) begin
                    if (!mux_out[DATA_WIDTH]) begin
                        state <= LOCKED;
                        owner <= xfer;
                    end
                end else if (mux_out[DATA_WIDTH]) begin
                    state <= IDLE;
                    owner <= '0;
                    rearb <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
        (state == IDLE) |-> $onehot0(gnt_raw));

endmodule

// File: tb/tb_xbar_out_port.sv
// Self-checking bench for xbar_out_port: directed scenarios plus randomized traffic against a packet-level model.
module tb_xbar_out_port;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_ready;
    logic [N-1:0]    arb_reqs;
    logic [N-1:0]    arb_grants;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            out_ready;

    always #5 clk = ~clk;

    xbar_out_port #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .arb_reqs   (arb_reqs),
        .arb_grants (arb_grants),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packet-level model: which input (if any) owns the port, whether we are in the
    // re-arbitration gap, and what the output register must hold.
    int            m_owner  = -1;
    bit            m_gap    = 1'b0;
    logic          m_ov     = 1'b0;
    logic          m_ol     = 1'b0;
    logic [DW-1:0] m_od     = '0;
    logic [N-1:0]  exp_ready;
    logic [N-1:0]  exp_reqs;

    task automatic set_flit(input int i, input logic [DW-1:0] d, input logic l);
        in_data[i*DW +: DW] = d;
        in_last[i]          = l;
    endtask

    // Mid-cycle: derive the expected handshake from current inputs and compare everything.
    task automatic settle();
        int pick;
        #3;
        exp_reqs  = (m_owner < 0) ? in_valid : (N'(1) << m_owner);
        exp_ready = '0;
        if (!rst && (!m_ov || out_ready) && !m_gap) begin
            if (m_owner >= 0) begin
                exp_ready = N'(1) << m_owner;
            end else begin
                pick = -1;
                for (int i = N - 1; i >= 0; i--)
                    if (in_valid[i] && arb_grants[i]) pick = i;
                if (pick >= 0) exp_ready = N'(1) << pick;
            end
        end
        check("in_ready",  in_ready,  exp_ready);
        check("arb_reqs",  arb_reqs,  exp_reqs);
        check("out_valid", out_valid, m_ov);
        check("out_data",  out_data,  m_od);
        check("out_last",  out_last,  m_ol);
    endtask

    task automatic tick();
        int xi;
        @(posedge clk);
        if (rst) begin
            m_owner = -1;
            m_gap   = 1'b0;
            m_ov    = 1'b0;
            m_ol    = 1'b0;
            m_od    = '0;
        end else begin
            xi = -1;
            for (int i = 0; i < N; i++)
                if (in_valid[i] && exp_ready[i]) xi = i;
            m_gap = 1'b0;
            if (xi >= 0) begin
                m_od = in_data[xi*DW +: DW];
                m_ol = in_last[xi];
                m_ov = 1'b1;
                if (m_owner < 0) begin
                    if (!in_last[xi]) m_owner = xi;
                end else if (in_last[xi]) begin
                    m_owner = -1;
                    m_gap   = 1'b1;
                end
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        int            xfers;
        int            pkt;
        int            cnt [N];
        int            k;
        logic [N-1:0]  hold;
        logic [N-1:0]  acc;
        int unsigned   seq;

        rst = 1'b1; in_valid = '0; in_data = '0; in_last = '0; arb_grants = '0; out_ready = 1'b1;
        tick();

        // Reset held: nothing may be accepted even with valid, granted inputs.
        in_valid = 4'b1111; arb_grants = 4'b0001;
        settle();
        check("rst_in_ready", in_ready, 4'b0000);
        check("rst_out_valid", out_valid, 1'b0);
        tick();
        rst = 1'b0;

        // Single-flit packet on input 2.
        in_valid = 4'b0100; arb_grants = 4'b0100; set_flit(2, 32'hA5A5_0002, 1'b1);
        settle();
        check("sf_in_ready", in_ready, 4'b0100);
        tick();
        in_valid = 4'b0001; arb_grants = 4'b0000;
        settle();
        check("sf_out_valid", out_valid, 1'b1);
        check("sf_out_data", out_data, 32'hA5A5_0002);
        check("sf_out_last", out_last, 1'b1);
        check("sf_still_idle", arb_reqs, 4'b0001);
        tick();

        // Grant pointing at an idle input.
        in_valid = 4'b0001; arb_grants = 4'b1000;
        settle();
        check("gi_in_ready", in_ready, 4'b0000);
        tick();
        in_valid = 4'b0000; arb_grants = 4'b0000;
        settle();
        check("gi_out_valid", out_valid, 1'b0);
        tick();

        // Packet lock: input 1 sends three flits while input 3 waits.
        in_valid = 4'b1010; arb_grants = 4'b0010;
        set_flit(1, 32'h11, 1'b0); set_flit(3, 32'h33, 1'b1);
        settle();
        check("pl_c1_ready", in_ready, 4'b0010);
        tick();
        set_flit(1, 32'h12, 1'b0); arb_grants = 4'b1000;
        settle();
        check("pl_c2_reqs", arb_reqs, 4'b0010);
        check("pl_c2_ready", in_ready, 4'b0010);
        check("pl_c2_data", out_data, 32'h11);
        tick();
        set_flit(1, 32'h13, 1'b1);
        settle();
        check("pl_c3_reqs", arb_reqs, 4'b0010);
        check("pl_c3_ready", in_ready, 4'b0010);
        check("pl_c3_data", out_data, 32'h12);
        tick();
        in_valid = 4'b1000;
        settle();
        check("pl_c4_gap", in_ready, 4'b0000);
        check("pl_c4_data", out_data, 32'h13);
        check("pl_c4_last", out_last, 1'b1);
        tick();
        settle();
        check("pl_c5_ready", in_ready, 4'b1000);
        tick();
        in_valid = 4'b0000; arb_grants = 4'b0000;
        settle();
        check("pl_c6_data", out_data, 32'h33);
        tick();

        // Backpressure in the middle of a 4-flit packet on input 0.
        in_valid = 4'b0001; arb_grants = 4'b0001; set_flit(0, 32'h01, 1'b0);
        settle(); tick();
        set_flit(0, 32'h02, 1'b0);
        settle(); tick();
        set_flit(0, 32'h03, 1'b0); out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            settle();
            check("bp_in_ready", in_ready, 4'b0000);
            check("bp_hold_data", out_data, 32'h02);
            tick();
        end
        out_ready = 1'b1;
        settle();
        check("bp_resume", in_ready, 4'b0001);
        tick();
        set_flit(0, 32'h04, 1'b1);
        settle();
        check("bp_f3", out_data, 32'h03);
        tick();
        in_valid = 4'b0000;
        settle();
        check("bp_f4", out_data, 32'h04);
        check("bp_f4_last", out_last, 1'b1);
        tick();

        // Reset on the second flit of a packet from input 1.
        in_valid = 4'b0010; arb_grants = 4'b0010; set_flit(1, 32'h21, 1'b0);
        settle(); tick();
        set_flit(1, 32'h22, 1'b0); rst = 1'b1;
        settle();
        check("rm_in_ready", in_ready, 4'b0000);
        tick();
        rst = 1'b0; in_valid = 4'b0110; arb_grants = 4'b0100; set_flit(2, 32'h41, 1'b1);
        settle();
        check("rm_out_valid", out_valid, 1'b0);
        check("rm_reqs", arb_reqs, 4'b0110);
        check("rm_new_ready", in_ready, 4'b0100);
        tick();
        in_valid = 4'b0000; arb_grants = 4'b0000;
        settle();
        check("rm_new_data", out_data, 32'h41);
        tick();

        // Throughput: inputs 0 and 2 stream 2-flit packets, grants alternate per packet.
        xfers = 0; pkt = 0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid   = 4'b0101;
            arb_grants = pkt[0] ? 4'b0100 : 4'b0001;
            set_flit(0, 32'h0A00_0000 + 32'(cnt[0]), cnt[0][0]);
            set_flit(2, 32'h0C00_0000 + 32'(cnt[2]), cnt[2][0]);
            settle();
            acc = in_valid & exp_ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    xfers++;
                    if (cnt[i][0]) pkt++;
                    cnt[i]++;
                end
            end
        end
        check("tp_flits_in_12", 64'(xfers), 64'd8);
        check("tp_packets", 64'(pkt), 64'd4);

        // Randomized traffic with per-input sources that hold a flit until it is taken.
        hold = '0; seq = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!hold[i]) begin
                    in_valid[i] = ($urandom_range(0, 9) < 6);
                    set_flit(i, {8'(i), 24'(seq)}, ($urandom_range(0, 2) == 0));
                    seq++;
                end
            end
            if (in_valid != '0 && $urandom_range(0, 3) != 0) begin
                do k = $urandom_range(0, N - 1); while (!in_valid[k]);
                arb_grants = N'(1) << k;
            end else begin
                k = $urandom_range(0, N);
                arb_grants = (k < N) ? (N'(1) << k) : '0;
            end
            out_ready = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 99) == 0);
            settle();
            acc = in_valid & exp_ready;
            tick();
            hold = in_valid & ~acc;
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
